periph_bridge_n: RTL and testbench

Parametrised, handshaked successor to the combinational CPU/peripheral bridge. It sits between the CPU data port, the DRAM and N memory-mapped peripheral slots. It accepts one CPU request at a time and decodes the address to DRAM, one peripheral slot, or unmapped. It then waits a fixed DRAM latency or a per-slot ready handshake (with timeout), and returns registered read data with a one-cycle ack and a bus-error flag.

---
 rtl/periph_bridge_n_pkg.sv | 31 +++
 rtl/periph_bridge_n_addr_decoder.sv | 36 +++
 rtl/periph_bridge_n.sv | 170 +++++++++++++++++
 tb/tb_periph_bridge_n.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bridge_n_pkg.sv
// Shared constants for the CPU/peripheral bridge.
//   PERI_PAGE        upper 20 address bits that select the peripheral page
//   PERI_ADDR_*      default slot addresses (slot0 DIG, 1 LED, 2 SW, 3 BTN)
//   BUS_ERR_DATA     read data returned on any bus error
//   ST_*             FSM state encodings
//   idx_w()          width of a slot index for a given slot count
//   sat_inc8()       saturating 8-bit increment for the error counter
package periph_bridge_n_pkg;

  localparam logic [19:0] PERI_PAGE     = 20'hFFFFF;
  localparam logic [31:0] PERI_ADDR_DIG = 32'hFFFFF000;
  localparam logic [31:0] PERI_ADDR_LED = 32'hFFFFF060;
  localparam logic [31:0] PERI_ADDR_SW  = 32'hFFFFF070;
  localparam logic [31:0] PERI_ADDR_BTN = 32'hFFFFF078;
  localparam logic [31:0] BUS_ERR_DATA  = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRAM     = 3'd1;
  localparam logic [2:0] ST_PERI     = 3'd2;
  localparam logic [2:0] ST_RESP_ERR = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/periph_bridge_n_addr_decoder.sv
// Combinational address decoder for the bridge.
//   i_addr      byte address to classify
//   o_hit_mem   address lies outside the peripheral page (DRAM)
//   o_hit_idx   index of the matching slot (lowest index wins)
//   o_hit_none  inside the peripheral page but no slot matches
module bridge_addr_decoder
  import periph_bridge_n_pkg::*;
#(
  parameter int N_PERI = 4,
  parameter logic [N_PERI*32-1:0] PERI_ADDRS =
    {PERI_ADDR_BTN, PERI_ADDR_SW, PERI_ADDR_LED, PERI_ADDR_DIG},
  localparam int IDX_W = idx_w(N_PERI)
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit_mem,
  output logic [IDX_W-1:0] o_hit_idx,
  output logic             o_hit_none
);

  logic w_found;

  always_comb begin
    o_hit_mem = (i_addr[31:12] != PERI_PAGE);
    w_found   = 1'b0;
    o_hit_idx = '0;
    // Scan from the top down so the lowest matching slot is the last one written.
    for (int k = N_PERI - 1; k >= 0; k--) begin
      if (i_addr == PERI_ADDRS[32*k +: 32]) begin
        w_found   = 1'b1;
        o_hit_idx = IDX_W'(k);
      end
    end
    o_hit_none = !o_hit_mem && !w_found;
  end

endmodule

// File: rtl/periph_bridge_n.sv
// Handshaked bridge between the CPU data port, DRAM and N peripheral slots.
// One request at a time: decode, wait on DRAM latency or slot rdy (with
// timeout), then return registered read data with a one-cycle ack.
//   clk_from_cpu / rst_from_cpu        clock, async active-high reset
//   req/addr/we/wdata_from_cpu         CPU request (sampled in IDLE only)
//   rdata/ack/err_to_cpu, err_cnt      CPU response and saturating error count
//   *_to_dram, rdata_from_dram         DRAM port
//   *_to_peri, rdata/rdy_from_peri     peripheral slot ports
//
// state       | meaning
// ST_IDLE     | waiting for req; latches addr/we/wdata on acceptance
// ST_DRAM     | DRAM access, DRAM_LAT cycles; write strobe in first cycle
// ST_PERI     | slot selected, waiting for its rdy or the timeout
// ST_RESP_ERR | unmapped address: ack with err, no target strobed
// ST_RESP     | one-cycle ack of a DRAM or slot access
module periph_bridge_n
  import periph_bridge_n_pkg::*;
#(
  parameter int N_PERI = 4,
  parameter logic [N_PERI*32-1:0] PERI_ADDRS =
    {PERI_ADDR_BTN, PERI_ADDR_SW, PERI_ADDR_LED, PERI_ADDR_DIG},
  parameter int DRAM_LAT = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk_from_cpu,
  input  logic                 rst_from_cpu,
  input  logic                 req_from_cpu,
  input  logic [31:0]          addr_from_cpu,
  input  logic                 we_from_cpu,
  input  logic [31:0]          wdata_from_cpu,
  output logic [31:0]          rdata_to_cpu,
  output logic                 ack_to_cpu,
  output logic                 err_to_cpu,
  output logic [7:0]           err_cnt,
  output logic [31:0]          addr_to_dram,
  output logic                 we_to_dram,
  output logic [31:0]          wdata_to_dram,
  input  logic [31:0]          rdata_from_dram,
  output logic [N_PERI-1:0]    sel_to_peri,
  output logic [N_PERI-1:0]    we_to_peri,
  output logic [31:0]          addr_to_peri,
  output logic [31:0]          wdata_to_peri,
  input  logic [N_PERI*32-1:0] rdata_from_peri,
  input  logic [N_PERI-1:0]    rdy_from_peri
);

  localparam int IDX_W   = idx_w(N_PERI);
  localparam int CNT_MAX = (TIMEOUT > DRAM_LAT) ? TIMEOUT : DRAM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [7:0]       r_err_cnt;

  logic             w_hit_mem;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_hit_none;
  logic [N_PERI-1:0] w_sel;
  logic [31:0]      w_slice;
  logic             w_rdy;
  logic             w_ack;

  bridge_addr_decoder #(
    .N_PERI     (N_PERI),
    .PERI_ADDRS (PERI_ADDRS)
  ) u_dec (
    .i_addr     (addr_from_cpu),
    .o_hit_mem  (w_hit_mem),
    .o_hit_idx  (w_hit_idx),
    .o_hit_none (w_hit_none)
  );

  // Only the latched slot's rdy/data are looked at; other slots are ignored.
  always_comb begin
    w_sel   = '0;
    w_slice = '0;
    w_rdy   = 1'b0;
    for (int k = 0; k < N_PERI; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_slice  = rdata_from_peri[32*k +: 32];
        w_rdy    = rdy_from_peri[k];
        w_sel[k] = (r_state == ST_PERI);
      end
    end
  end

  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_from_cpu) begin
            r_addr  <= addr_from_cpu;
            r_we    <= we_from_cpu;
            r_wdata <= wdata_from_cpu;
            if (w_hit_mem) begin
              r_state <= ST_DRAM;
              r_cnt   <= CNT_W'(DRAM_LAT - 1);
            end else if (w_hit_none) begin
              r_state   <= ST_RESP_ERR;
              r_rdata   <= BUS_ERR_DATA;
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc8(r_err_cnt);
            end else begin
              r_state <= ST_PERI;
              r_idx   <= w_hit_idx;
              r_cnt   <= CNT_W'(TIMEOUT);
            end
          end
        end
        ST_DRAM: begin
          if (r_cnt == '0) begin
            r_rdata <= rdata_from_dram;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_PERI: begin
          // rdy is tested before the terminal count, so rdy on the last
          // allowed cycle still completes successfully.
          if (w_rdy) begin
            r_rdata <= r_we ? 32'h0 : w_slice;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else if (r_cnt <= CNT_W'(1)) begin
            r_rdata   <= BUS_ERR_DATA;
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc8(r_err_cnt);
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP, ST_RESP_ERR: r_state <= ST_IDLE;
        default:              r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_ack         = (r_state == ST_RESP) || (r_state == ST_RESP_ERR);
  assign ack_to_cpu    = w_ack;
  assign err_to_cpu    = r_err & w_ack;
  assign rdata_to_cpu  = r_rdata;
  assign err_cnt       = r_err_cnt;
  assign addr_to_dram  = r_addr;
  assign wdata_to_dram = r_wdata;
  assign addr_to_peri  = r_addr;
  assign wdata_to_peri = r_wdata;
  assign we_to_dram    = (r_state == ST_DRAM) && (r_cnt == CNT_W'(DRAM_LAT - 1)) && r_we;
  assign sel_to_peri   = w_sel;
  assign we_to_peri    = w_sel & {N_PERI{r_we}};

endmodule

// File: tb/tb_periph_bridge_n.sv
module tb_periph_bridge_n;

  localparam int N_PERI   = 4;
  localparam int DRAM_LAT = 1;
  localparam int TIMEOUT  = 16;
  localparam int K_MEM = 0, K_PERI = 1, K_NONE = 2;
  localparam logic [31:0] SLOT_ADDR [N_PERI] =
    '{32'hFFFFF000, 32'hFFFFF060, 32'hFFFFF070, 32'hFFFFF078};

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 req = 1'b0;
  logic [31:0]          addr_in = '0;
  logic                 we_in = 1'b0;
  logic [31:0]          wdata_in = '0;
  logic [31:0]          rdata_to_cpu;
  logic                 ack_to_cpu;
  logic                 err_to_cpu;
  logic [7:0]           err_cnt;
  logic [31:0]          addr_to_dram;
  logic                 we_to_dram;
  logic [31:0]          wdata_to_dram;
  logic [31:0]          rdata_from_dram = '0;
  logic [N_PERI-1:0]    sel_to_peri;
  logic [N_PERI-1:0]    we_to_peri;
  logic [31:0]          addr_to_peri;
  logic [31:0]          wdata_to_peri;
  logic [N_PERI*32-1:0] rdata_from_peri = '0;
  logic [N_PERI-1:0]    rdy_from_peri = '0;

  periph_bridge_n #(
    .N_PERI     (N_PERI),
    .PERI_ADDRS ({32'hFFFFF078, 32'hFFFFF070, 32'hFFFFF060, 32'hFFFFF000}),
    .DRAM_LAT   (DRAM_LAT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_from_cpu    (clk),
    .rst_from_cpu    (rst),
    .req_from_cpu    (req),
    .addr_from_cpu   (addr_in),
    .we_from_cpu     (we_in),
    .wdata_from_cpu  (wdata_in),
    .rdata_to_cpu    (rdata_to_cpu),
    .ack_to_cpu      (ack_to_cpu),
    .err_to_cpu      (err_to_cpu),
    .err_cnt         (err_cnt),
    .addr_to_dram    (addr_to_dram),
    .we_to_dram      (we_to_dram),
    .wdata_to_dram   (wdata_to_dram),
    .rdata_from_dram (rdata_from_dram),
    .sel_to_peri     (sel_to_peri),
    .we_to_peri      (we_to_peri),
    .addr_to_peri    (addr_to_peri),
    .wdata_to_peri   (wdata_to_peri),
    .rdata_from_peri (rdata_from_peri),
    .rdy_from_peri   (rdy_from_peri)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs for the current cycle, set by the driver from the
  // transaction-level rules.
  logic              exp_ack     = 1'b0;
  logic              exp_err     = 1'b0;
  logic [31:0]       exp_rdata   = '0;
  logic [N_PERI-1:0] exp_sel     = '0;
  logic [N_PERI-1:0] exp_we_peri = '0;
  logic              exp_we_dram = 1'b0;
  logic [31:0]       exp_addr    = '0;
  logic [31:0]       exp_wdata   = '0;
  logic [7:0]        m_err_cnt   = '0;

  int          req_cyc = 0;
  int          mon_ack_cyc = -100;
  logic [31:0] mon_rdata = '0;
  logic        mon_err = 1'b0;
  int          mon_sel_cycles = 0;
  int          mon_we_dram_cycles = 0;
  int          mon_we_peri_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_decode(input logic [31:0] a, output int kind, output int k);
    kind = K_NONE;
    k    = 0;
    if (a[31:12] != 20'hFFFFF) kind = K_MEM;
    else
      for (int s = 0; s < N_PERI; s++)
        if (kind == K_NONE && a == SLOT_ADDR[s]) begin
          kind = K_PERI;
          k    = s;
        end
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("ack", 32'(ack_to_cpu), 32'(exp_ack));
    chk("err", 32'(err_to_cpu), 32'(exp_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    chk("sel_to_peri", 32'(sel_to_peri), 32'(exp_sel));
    chk("we_to_peri", 32'(we_to_peri), 32'(exp_we_peri));
    chk("we_to_dram", 32'(we_to_dram), 32'(exp_we_dram));
    chk("addr_to_dram", addr_to_dram, exp_addr);
    chk("addr_to_peri", addr_to_peri, exp_addr);
    chk("wdata_to_dram", wdata_to_dram, exp_wdata);
    chk("wdata_to_peri", wdata_to_peri, exp_wdata);
    if (exp_ack) chk("rdata_to_cpu", rdata_to_cpu, exp_rdata);
    if (ack_to_cpu) begin
      mon_ack_cyc = cyc;
      mon_rdata   = rdata_to_cpu;
      mon_err     = err_to_cpu;
    end
    if (|sel_to_peri) mon_sel_cycles++;
    if (we_to_dram)   mon_we_dram_cycles++;
    if (|we_to_peri)  mon_we_peri_cycles++;
  end

  // One complete transaction; entered and left at posedge+1 of an IDLE cycle.
  // dly = PERI cycles before rdy of the addressed slot (>= TIMEOUT: never).
  task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int dly, input logic [31:0] slice, input logic [31:0] dd);
    int kind, k, n_busy;
    logic [31:0] rd;
    logic e;
    model_decode(a, kind, k);
    req = 1'b1; addr_in = a; we_in = w; wdata_in = wd; rdata_from_dram = dd;
    for (int s = 0; s < N_PERI; s++) rdata_from_peri[32*s +: 32] = $urandom;
    if (kind == K_PERI) rdata_from_peri[32*k +: 32] = slice;
    rdy_from_peri = '0;
    mon_sel_cycles = 0; mon_we_dram_cycles = 0; mon_we_peri_cycles = 0;
    mon_ack_cyc = -100;
    step();
    req_cyc   = cyc;
    exp_addr  = a;
    exp_wdata = wd;
    addr_in = $urandom; we_in = 1'($urandom); wdata_in = $urandom;
    if (kind == K_MEM) begin
      n_busy = DRAM_LAT; rd = dd; e = 1'b0;
    end else if (kind == K_PERI) begin
      if (dly < TIMEOUT) begin
        n_busy = dly + 1; rd = w ? 32'h0 : slice; e = 1'b0;
      end else begin
        n_busy = TIMEOUT; rd = 32'hFFFF_FFFF; e = 1'b1;
      end
    end else begin
      n_busy = 0; rd = 32'hFFFF_FFFF; e = 1'b1;
    end
    for (int i = 0; i < n_busy; i++) begin
      exp_we_dram = (kind == K_MEM) && w && (i == 0);
      exp_sel     = (kind == K_PERI) ? N_PERI'(1 << k) : '0;
      exp_we_peri = w ? exp_sel : '0;
      rdy_from_peri = N_PERI'($urandom);
      if (kind == K_PERI) rdy_from_peri[k] = (i == dly);
      step();
    end
    exp_we_dram = 1'b0; exp_sel = '0; exp_we_peri = '0; rdy_from_peri = '0;
    exp_ack = 1'b1; exp_err = e; exp_rdata = rd;
    if (e && m_err_cnt != 8'd255) m_err_cnt = m_err_cnt + 8'd1;
    req = 1'($urandom);
    step();
    exp_ack = 1'b0; exp_err = 1'b0; req = 1'b0;
  endtask

  function automatic int lat();
    return mon_ack_cyc - req_cyc + 1;
  endfunction

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_rdata", rdata_to_cpu, 32'h0);
    chk("rst_ack", 32'(ack_to_cpu), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_sel", 32'(sel_to_peri), 32'h0);
    chk("rst_addr_dram", addr_to_dram, 32'h0);
    step();
    rst = 1'b0;
    step();

    // DRAM read
    do_txn(32'h0000_0040, 1'b0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
    chk("dram_rd_lat", lat(), 2);
    chk("dram_rd_rdata", mon_rdata, 32'hDEAD_BEEF);
    chk("dram_rd_err", 32'(mon_err), 32'h0);
    chk("dram_rd_we_cycles", mon_we_dram_cycles, 0);

    // DRAM write
    do_txn(32'h0000_0010, 1'b1, 32'h1234_5678, 0, 32'h0, $urandom);
    chk("dram_wr_we_cycles", mon_we_dram_cycles, 1);
    chk("dram_wr_lat", lat(), 2);
    chk("dram_wr_sel_cycles", mon_sel_cycles, 0);
    chk("dram_wr_addr", addr_to_dram, 32'h0000_0010);
    chk("dram_wr_wdata", wdata_to_dram, 32'h1234_5678);

    // Peripheral with wait states (slot 2)
    do_txn(32'hFFFFF070, 1'b0, 32'h0, 3, 32'h0000_00A5, $urandom);
    chk("peri_wait_sel_cycles", mon_sel_cycles, 4);
    chk("peri_wait_rdata", mon_rdata, 32'h0000_00A5);
    chk("peri_wait_lat", lat(), 5);
    chk("peri_wait_err", 32'(mon_err), 32'h0);

    // rdy on the timeout edge still succeeds
    do_txn(32'hFFFFF000, 1'b0, 32'h0, TIMEOUT - 1, 32'h5A5A_0001, $urandom);
    chk("rdy_at_timeout_err", 32'(mon_err), 32'h0);
    chk("rdy_at_timeout_rdata", mon_rdata, 32'h5A5A_0001);
    chk("rdy_at_timeout_sel_cycles", mon_sel_cycles, 16);

    // Timeout
    do_txn(32'hFFFFF078, 1'b0, 32'h0, 1000, 32'h0, $urandom);
    chk("timeout_err", 32'(mon_err), 32'h1);
    chk("timeout_rdata", mon_rdata, 32'hFFFF_FFFF);
    chk("timeout_err_cnt", 32'(err_cnt), 32'h1);
    chk("timeout_sel_cycles", mon_sel_cycles, 16);
    chk("timeout_lat", lat(), 17);

    // Unmapped, then saturation of err_cnt
    do_txn(32'hFFFFF004, 1'b1, $urandom, 0, 32'h0, $urandom);
    chk("unmapped_lat", lat(), 1);
    chk("unmapped_err", 32'(mon_err), 32'h1);
    chk("unmapped_we_dram", mon_we_dram_cycles, 0);
    chk("unmapped_we_peri", mon_we_peri_cycles, 0);
    chk("unmapped_err_cnt", 32'(err_cnt), 32'h2);
    for (int n = 1; n < 300; n++) do_txn(32'hFFFFF004, 1'b1, $urandom, 0, 32'h0, $urandom);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    // Reset in the middle of a PERI wait
    req = 1'b1; addr_in = 32'hFFFFF078; we_in = 1'b0; wdata_in = 32'hCAFE_0000;
    rdy_from_peri = '0;
    step();
    exp_addr = 32'hFFFFF078; exp_wdata = 32'hCAFE_0000; exp_sel = 4'b1000;
    step();
    step();
    #2;
    rst = 1'b1;
    exp_sel = '0; exp_we_peri = '0; exp_addr = '0; exp_wdata = '0; m_err_cnt = '0;
    #1;
    chk("midrst_ack", 32'(ack_to_cpu), 32'h0);
    chk("midrst_sel", 32'(sel_to_peri), 32'h0);
    chk("midrst_rdata", rdata_to_cpu, 32'h0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'h0);
    chk("midrst_addr_peri", addr_to_peri, 32'h0);
    req = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Back-to-back LED write then SW read
    do_txn(32'hFFFFF060, 1'b1, 32'h0000_0055, 0, $urandom, $urandom);
    chk("b2b_led_lat", lat(), 2);
    chk("b2b_led_err", 32'(mon_err), 32'h0);
    chk("b2b_led_rdata", mon_rdata, 32'h0);
    do_txn(32'hFFFFF070, 1'b0, $urandom, 2, 32'hC0FF_EE01, $urandom);
    chk("b2b_sw_lat", lat(), 4);
    chk("b2b_sw_rdata", mon_rdata, 32'hC0FF_EE01);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r, q, d;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 3)      a = {20'($urandom_range(0, 20'hFFFFE)), 12'($urandom)};
      else if (r < 8) a = SLOT_ADDR[$urandom_range(0, N_PERI - 1)];
      else            a = {20'hFFFFF, 12'($urandom)};
      q = $urandom_range(0, 9);
      if (q == 0)      d = TIMEOUT - 1;
      else if (q == 1) d = TIMEOUT + $urandom_range(0, 3);
      else             d = $urandom_range(0, 5);
      do_txn(a, 1'($urandom), $urandom, d, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t, required finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
